// File: rtl/integral_pkg.sv
// Shared types and defaults for the streaming integral-image window generator.
package integral_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_PIX_W = 8;
  localparam int DEFAULT_WIN_W = 20;
  localparam int DEFAULT_WIN_H = 20;
  localparam int DEFAULT_ACC_W = 32;

  // Never returns a zero width, so a 1x1 window still gets a 1-bit address.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Luma approximation (r + 2g + b) / 4; the caller truncates to its pixel width.
  function automatic int unsigned rgb2gray(input int unsigned r, input int unsigned g,
                                           input int unsigned b);
    return (r + 2 * g + b) >> 2;
  endfunction

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational RGB to grayscale conversion, kept separate so it can be tested alone.
module rgb_to_gray
  import integral_pkg::*;
#(
  parameter int PIX_W = DEFAULT_PIX_W
) (
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] gray
);

  assign gray = PIX_W'(rgb2gray(32'(r), 32'(g), 32'(b)));

endmodule

// File: rtl/integral_window_gen.sv
// Streaming summed-area table builder with a registered random-access read port.
// Define SQ_INTEGRAL_EN to also build the squared-integral table on rd_sq_data.
module integral_window_gen
  import integral_pkg::*;
#(
  parameter int PIX_W  = DEFAULT_PIX_W,
  parameter int WIN_W  = DEFAULT_WIN_W,
  parameter int WIN_H  = DEFAULT_WIN_H,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int ADDR_W = addr_width(WIN_W * WIN_H)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [PIX_W-1:0]     pix_r,
  input  logic [PIX_W-1:0]     pix_g,
  input  logic [PIX_W-1:0]     pix_b,
  output logic                 busy,
  output logic                 done,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [ACC_W-1:0]     rd_data,
  output logic [2*ACC_W-1:0]   rd_sq_data
);

  localparam int N    = WIN_W * WIN_H;
  localparam int XW   = addr_width(WIN_W);
  localparam int SQ_W = 2 * ACC_W;

  state_t            state_reg;
  logic [XW-1:0]     x_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ACC_W-1:0]  row_acc_reg;
  logic [PIX_W-1:0]  gray;
  logic              accept;
  logic              rd_ok;
  logic              first_col;
  logic              first_row;
  logic              last_pix;
  logic [ACC_W-1:0]  row_sum;
  logic [ACC_W-1:0]  ii_above;
  logic [ACC_W-1:0]  ii_val;
  logic [ACC_W-1:0]  ii_mem [N];

  rgb_to_gray #(.PIX_W(PIX_W)) u_gray (
    .r    (pix_r),
    .g    (pix_g),
    .b    (pix_b),
    .gray (gray)
  );

  // A beat offered alongside start is refused so a restart never swallows pixel 0.
  assign pix_ready = (state_reg == ACCUM) && !start;
  assign accept    = pix_valid && pix_ready;
  assign busy      = (state_reg == ACCUM);
  assign done      = (state_reg == DONE);
  assign first_col = (x_reg == '0);
  assign first_row = (32'(idx_reg) < WIN_W);
  assign last_pix  = (32'(idx_reg) == N - 1);
  assign rd_ok     = (state_reg == DONE) && !start && (32'(rd_addr) < N);

  always_comb begin
    ii_above = '0;
    if (!first_row) begin
      ii_above = ii_mem[idx_reg - ADDR_W'(WIN_W)];
    end
    row_sum = (first_col ? '0 : row_acc_reg) + ACC_W'(gray);
    ii_val  = row_sum + ii_above;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      idx_reg     <= '0;
      row_acc_reg <= '0;
      rd_data     <= '0;
    end else begin
      if (start) begin
        state_reg   <= ACCUM;
        x_reg       <= '0;
        idx_reg     <= '0;
        row_acc_reg <= '0;
      end else if (accept) begin
        row_acc_reg <= row_sum;
        idx_reg     <= idx_reg + 1'b1;
        x_reg       <= (32'(x_reg) == WIN_W - 1) ? '0 : x_reg + 1'b1;
        if (last_pix) begin
          state_reg <= DONE;
        end
      end
      rd_data <= rd_ok ? ii_mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && !RESET) begin
      ii_mem[idx_reg] <= ii_val;
    end
  end

`ifdef SQ_INTEGRAL_EN
  logic [SQ_W-1:0] sq_row_acc_reg;
  logic [SQ_W-1:0] sq_row_sum;
  logic [SQ_W-1:0] sq_above;
  logic [SQ_W-1:0] sq_val;
  logic [SQ_W-1:0] sq_mem [N];

  always_comb begin
    sq_above = '0;
    if (!first_row) begin
      sq_above = sq_mem[idx_reg - ADDR_W'(WIN_W)];
    end
    sq_row_sum = (first_col ? '0 : sq_row_acc_reg) + SQ_W'(gray) * SQ_W'(gray);
    sq_val     = sq_row_sum + sq_above;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sq_row_acc_reg <= '0;
      rd_sq_data     <= '0;
    end else begin
      if (start) begin
        sq_row_acc_reg <= '0;
      end else if (accept) begin
        sq_row_acc_reg <= sq_row_sum;
      end
      rd_sq_data <= rd_ok ? sq_mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept && !RESET) begin
      sq_mem[idx_reg] <= sq_val;
    end
  end
`else
  assign rd_sq_data = '0;
`endif

endmodule

// File: tb/tb_integral_window_gen.sv
// Self-checking bench: 20x20 window against an arithmetic summed-area model, plus 1x1 conversion table.
module tb_integral_window_gen;

  localparam int PIX_W  = 8;
  localparam int WIN_W  = 20;
  localparam int WIN_H  = 20;
  localparam int ACC_W  = 32;
  localparam int N      = WIN_W * WIN_H;
  localparam int ADDR_W = 9;
`ifdef SQ_INTEGRAL_EN
  localparam bit SQ_ON = 1'b1;
`else
  localparam bit SQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main 20x20 instance
  logic               start, pix_valid, pix_ready, busy, done;
  logic [PIX_W-1:0]   pix_r, pix_g, pix_b;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ACC_W-1:0]   rd_data;
  logic [2*ACC_W-1:0] rd_sq_data;

  integral_window_gen #(.PIX_W(PIX_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .ACC_W(ACC_W)) dut (
    .CLK(clk), .RESET(rst), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_sq_data(rd_sq_data)
  );

  // 1x1 instance used for grayscale conversion vectors
  logic               start1, valid1, ready1, busy1, done1;
  logic [PIX_W-1:0]   r1, g1, b1;
  logic [0:0]         rd_addr1;
  logic [ACC_W-1:0]   rd_data1;
  logic [2*ACC_W-1:0] rd_sq1;

  integral_window_gen #(.PIX_W(PIX_W), .WIN_W(1), .WIN_H(1), .ACC_W(ACC_W)) dut1 (
    .CLK(clk), .RESET(rst), .start(start1), .pix_valid(valid1), .pix_ready(ready1),
    .pix_r(r1), .pix_g(g1), .pix_b(b1), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_sq_data(rd_sq1)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int acc_mon = 0;

  // Stimulus pixels and their model gray values
  int r_arr [N];
  int g_arr [N];
  int b_arr [N];
  int gm    [N];

  typedef struct {
    int r;
    int g;
    int b;
    int exp_gray;
  } conv_vec_t;
  conv_vec_t conv_tbl [10];

  always @(posedge clk) begin
    if (!rst && pix_valid && pix_ready) acc_mon++;
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Summed-area value straight from its definition: sum of gray over the top-left rectangle.
  function automatic longint unsigned ref_ii(input int a, input bit sq);
    int x = a % WIN_W;
    int y = a / WIN_W;
    longint unsigned s = 0;
    for (int yy = 0; yy <= y; yy++)
      for (int xx = 0; xx <= x; xx++) begin
        longint unsigned v = longint'(gm[yy * WIN_W + xx]);
        s += sq ? v * v : v;
      end
    return s;
  endfunction

  task automatic set_pix(input int i, input int r, input int g, input int b);
    r_arr[i] = r; g_arr[i] = g; b_arr[i] = b;
    gm[i] = (r + 2 * g + b) / 4;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1; pix_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct);
    int sent = 0;
    int cycles = 0;
    while (sent < n && cycles < 20000) begin
      @(negedge clk);
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_r = PIX_W'(r_arr[sent]); pix_g = PIX_W'(g_arr[sent]); pix_b = PIX_W'(b_arr[sent]);
      #1;
      if (pix_valid && pix_ready) sent++;
      cycles++;
    end
    @(negedge clk); pix_valid = 1'b0;
    if (sent < n) begin
      n_cmp++; n_fail++;
      $display("FAIL feed_timeout: got %0d beats required %0d", sent, n);
    end
  endtask

  task automatic do_read(input int addr, output longint unsigned d, output longint unsigned sq);
    @(negedge clk); rd_addr = ADDR_W'(addr);
    @(posedge clk); #1;
    d = rd_data; sq = rd_sq_data;
  endtask

  task automatic check_all(input string tag);
    longint unsigned d, sq;
    for (int a = 0; a < N; a++) begin
      do_read(a, d, sq);
      check($sformatf("%s_ii[%0d]", tag, a), d, ref_ii(a, 1'b0));
      check($sformatf("%s_sq[%0d]", tag, a), sq, SQ_ON ? ref_ii(a, 1'b1) : 64'd0);
    end
  endtask

  initial begin
    longint unsigned d, sq;
    int base;

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_r = '0; pix_g = '0; pix_b = '0; rd_addr = '0;
    start1 = 1'b0; valid1 = 1'b0; r1 = '0; g1 = '0; b1 = '0; rd_addr1 = '0;

    conv_tbl[0] = '{255, 0, 1, 64};
    conv_tbl[1] = '{255, 255, 255, 255};
    conv_tbl[2] = '{0, 0, 0, 0};
    conv_tbl[3] = '{1, 1, 1, 1};
    conv_tbl[4] = '{3, 0, 0, 0};
    conv_tbl[5] = '{0, 2, 0, 1};
    conv_tbl[6] = '{100, 50, 200, 100};
    conv_tbl[7] = '{10, 20, 30, 20};
    conv_tbl[8] = '{255, 255, 0, 191};
    conv_tbl[9] = '{0, 255, 255, 191};

    repeat (3) @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", pix_ready, 0);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_sq", rd_sq_data, 0);
    @(negedge clk); rst = 1'b0;

    do_read(7, d, sq);
    check("idle_read", d, 0);

    // Flat white, valid held high
    for (int i = 0; i < N; i++) set_pix(i, 255, 255, 255);
    do_start();
    base = acc_mon;
    feed(N, 0);
    check("white_done", done, 1);
    check("white_busy", busy, 0);
    @(negedge clk); pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    pix_valid = 1'b0;
    check("white_accepts", acc_mon - base, N);
    do_read(399, d, sq); check("white_ii399", d, 102000);
    check("white_sq399", sq, SQ_ON ? 64'd26010000 : 64'd0);
    do_read(0, d, sq);   check("white_ii0", d, 255);
    do_read(19, d, sq);  check("white_ii19", d, 5100);
    do_read(20, d, sq);  check("white_ii20", d, 510);
    for (int a = 400; a < 512; a++) begin
      do_read(a, d, sq);
      check($sformatf("oob_ii[%0d]", a), d, 0);
      check($sformatf("oob_sq[%0d]", a), sq, 0);
    end

    // start in DONE: done and rd_data drop at the sampling edge
    @(negedge clk); rd_addr = ADDR_W'(399); start = 1'b1;
    @(posedge clk); #1;
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    check("restart_rd_data", rd_data, 0);
    @(negedge clk); start = 1'b0;

    // Ramp gray = x + y with random gaps
    for (int i = 0; i < N; i++) set_pix(i, i % WIN_W + i / WIN_W, i % WIN_W + i / WIN_W, i % WIN_W + i / WIN_W);
    do_start();
    base = acc_mon;
    feed(N, 40);
    check("ramp_done", done, 1);
    check("ramp_accepts", acc_mon - base, N);
    check_all("ramp");

    // Random RGB with random gaps
    for (int i = 0; i < N; i++) set_pix(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    do_start();
    base = acc_mon;
    feed(N, 30);
    check("rand_accepts", acc_mon - base, N);
    check_all("rand");

    // Restart mid-window; beat offered with start must be refused
    for (int i = 0; i < N; i++) set_pix(i, 7, 7, 7);
    do_start();
    feed(150, 10);
    base = acc_mon;
    @(negedge clk); start = 1'b1; pix_valid = 1'b1; pix_r = 8'd5; pix_g = 8'd5; pix_b = 8'd5;
    #1; check("start_cycle_ready", pix_ready, 0);
    @(negedge clk); start = 1'b0; pix_valid = 1'b0;
    check("start_cycle_accepts", acc_mon - base, 0);
    for (int i = 0; i < N; i++) set_pix(i, 1, 1, 1);
    feed(N, 25);
    check("mid_restart_accepts", acc_mon - base, N);
    do_read(399, d, sq); check("mid_restart_ii399", d, 400);
    do_read(0, d, sq);   check("mid_restart_ii0", d, 1);
    do_read(21, d, sq);  check("mid_restart_ii21", d, 4);

    // RESET during ACCUM
    do_start();
    feed(50, 20);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_ready", pix_ready, 0);
    @(negedge clk); rst = 1'b0;
    do_read(5, d, sq); check("rst_mid_idle_read", d, 0);

    // RESET and start together: reset wins
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    #1; check("rst_start_busy", busy, 0);

    // 1x1 window conversion table
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0; valid1 = 1'b1;
      r1 = PIX_W'(conv_tbl[i].r); g1 = PIX_W'(conv_tbl[i].g); b1 = PIX_W'(conv_tbl[i].b);
      @(negedge clk); valid1 = 1'b0; rd_addr1 = 1'b0;
      check($sformatf("conv_done[%0d]", i), done1, 1);
      @(posedge clk); #1;
      check($sformatf("conv_gray[%0d]", i), rd_data1, conv_tbl[i].exp_gray);
      check($sformatf("conv_sq[%0d]", i), rd_sq1,
            SQ_ON ? longint'(conv_tbl[i].exp_gray) * longint'(conv_tbl[i].exp_gray) : 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/integral_window_gen.md
Name: integral_window_gen

Overview:
- Streaming integral-image generator for the face-detection classifier.
- Accepts one RGB pixel per handshake in raster order for a WIN_W x WIN_H detection window, converts it to grayscale, and builds the summed-area table in on-chip registers.
- Exposes the finished table through a registered random-access read port for the Haar-feature evaluator.
- Parametrised in pixel width, window size and accumulator width; adds start/done control and valid/ready backpressure.

Parameters:
PIX_W, 8, bits per colour channel
WIN_W, 20, window width in pixels
WIN_H, 20, window height in pixels
ACC_W, 32, integral word width; must be >= PIX_W + clog2(WIN_W*WIN_H)
ADDR_W, clog2(WIN_W*WIN_H), read address width (derived)

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin a new window
pix_valid  in  1  pixel beat valid
pix_ready  out  1  block accepts pixel this cycle
pix_r  in  PIX_W  red
pix_g  in  PIX_W  green
pix_b  in  PIX_W  blue
busy  out  1  high in ACCUM
done  out  1  high in DONE; table complete
rd_addr  in  ADDR_W  read address, y*WIN_W + x
rd_data  out  ACC_W  integral value II(x,y), registered
rd_sq_data  out  2*ACC_W  squared integral; only meaningful with SQ_INTEGRAL_EN

Behaviour:
- Reset (RESET=1 at an edge): state IDLE; x=0, y=0; row accumulator 0; rd_data=0; rd_sq_data=0. Outputs busy=0, done=0, pix_ready=0. Table contents are don't-care.
- States: IDLE, ACCUM, DONE.
  - IDLE -> ACCUM on start.
  - ACCUM -> DONE on acceptance of pixel index WIN_W*WIN_H-1.
  - DONE -> ACCUM on start.
  - start in ACCUM restarts: x, y and row accumulator cleared, state stays ACCUM.
- pix_ready = (state==ACCUM) && !start. This is combinational from start. A beat presented in the same cycle as start is not accepted.
- Accept = pix_valid && pix_ready. Gaps and backpressure are legal; no pixel is lost or duplicated.
- Gray: g = (r + 2*g + b) >> 2, computed at PIX_W+2 bits, truncated to PIX_W. Range 0..2^PIX_W-1.
- Per accepted pixel at (x,y):
  - rowsum = (x==0 ? 0 : rowacc) + g.
  - II(x,y) = rowsum + (y==0 ? 0 : II(x,y-1)).
  - Write II(x,y) to entry y*WIN_W+x; rowacc <= rowsum.
  - Then x increments; at x==WIN_W-1, x wraps to 0 and y increments.
- All arithmetic is unsigned at ACC_W bits, with no saturation. Wrap is legal only if ACC_W is under-sized, and that is a parameter error.
- done rises the cycle after the last pixel is accepted and holds until start or RESET. busy = (state==ACCUM).
- Read port:
  - rd_data <= table[rd_addr] when state==DONE and rd_addr < WIN_W*WIN_H; otherwise 0.
  - Latency is 1 cycle, and a new address can be issued every cycle.
- A start issued in DONE drops done the next cycle. rd_data is 0 from that edge onward.
- RESET mid-ACCUM: the window is abandoned; IDLE the next cycle.
- RESET and start in the same cycle: RESET wins.

Optional Feature:
- SQ_INTEGRAL_EN defined: a second table holds the squared integral, SQ(x,y) = sum of g*g, at 2*ACC_W bits. It uses the same recurrence and write timing and a parallel row accumulator. rd_sq_data follows the same read rules as rd_data. Used for variance normalisation.
- SQ_INTEGRAL_EN undefined: no second table; rd_sq_data is tied to 0.

Decomposition:
- integral_pkg holds:
  - the state enum (IDLE/ACCUM/DONE);
  - the default parameter constants (PIX_W, WIN_W, WIN_H, ACC_W);
  - an rgb2gray function.
- One sub-module, rgb_to_gray (combinational, parametrised on PIX_W). It keeps the conversion unit-testable.
- Table storage stays inline.

Test Plan:
- Flat white: start, then 400 beats with R=G=B=255, pix_valid held high -> done after 400 accepts. rd_addr=399 gives 102000; rd_addr=0 gives 255; rd_addr=19 gives 5100; rd_addr=20 gives 510.
- Ramp with random gaps: gray value = x+y (R=G=B), pix_valid randomly toggled -> every rd_addr matches the reference model; exactly 400 accepts counted.
- Conversion: single pixel R=255, G=0, B=1 in a 1x1 window (WIN_W=WIN_H=1) -> rd_data=64.
- Restart mid-window: start after 150 pixels, then 400 pixels of value 1 -> rd_addr=399 gives 400. A beat presented in the start cycle is not accepted.
- Reset and out-of-range reads:
  - RESET during ACCUM -> IDLE, done=0, pix_ready=0 the next cycle.
  - In DONE, rd_addr=400..511 -> rd_data=0.
  - In IDLE, any rd_addr -> rd_data=0.
- SQ_INTEGRAL_EN: flat white window -> rd_sq_data at addr 399 = 26010000. Without the macro -> rd_sq_data=0.
